// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the fetch FSM state type, the sequential PC step and the default reset vector.
package pc_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES          = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  function automatic logic isMisaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_branch_target.sv
// Branch target adder: PC of the resolved branch plus its sign-extended immediate.
// The sum wraps modulo 2^32; the carry out is intentionally dropped.
module Branch_Target (
  input  logic [31:0] i_imm,
  input  logic [31:0] i_pc,
  output logic [31:0] o_target
);

  assign o_target = i_pc + i_imm;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Instruction fetch sequencer: issues PC fetches, hands instructions to decode,
// and applies branch / jalr redirects including kill of an in-flight request.
module pc_fetch_sequencer
#(
  parameter logic [31:0] RESET_VECTOR = pc_fetch_sequencer_pkg::DEFAULT_RESET_VECTOR,
  parameter int unsigned INSTR_BYTES  = pc_fetch_sequencer_pkg::INSTR_BYTES
)
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic [31:0] branch_imm,
  input  logic        jalr_en,
  input  logic [31:0] jalr_target,
  output logic        misalign_err
);

  import pc_fetch_sequencer_pkg::*;

  localparam logic [31:0] PC_STEP = 32'(INSTR_BYTES);

  fetch_state_t r_state;
  fetch_state_t w_stateNext;
  logic [31:0]  r_pc;
  logic [31:0]  w_pcNext;
  logic [31:0]  r_addr;
  logic [31:0]  w_addrNext;
  logic [31:0]  r_instrOut;
  logic [31:0]  r_instrPc;
  logic         r_kill;
  logic         w_killNext;
  logic         w_latch;

  logic [31:0]  w_branchTarget;
  logic [31:0]  w_jalrTarget;
  logic [31:0]  w_target;
  logic         w_redirect;
  logic         w_targetBad;

  Branch_Target u_branchTarget (
    .i_imm    (branch_imm),
    .i_pc     (branch_pc),
    .o_target (w_branchTarget)
  );

  // jalr has priority over a coincident branch and always lands on an even address
  assign w_jalrTarget = {jalr_target[31:1], 1'b0};
  assign w_redirect   = jalr_en | branch_taken;
  assign w_target     = jalr_en ? w_jalrTarget : w_branchTarget;
  assign w_targetBad  = isMisaligned(w_target);

  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_killNext  = r_kill;
    w_latch     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_stateNext = ST_REQ;
        if (w_redirect) w_pcNext = w_target;
      end
      ST_REQ: begin
        if (w_redirect) begin
          w_pcNext   = w_target;
          w_killNext = ~imem_ack;
        end else if (imem_ack) begin
          if (r_kill) begin
            w_killNext = 1'b0;
          end else begin
            w_latch     = 1'b1;
            w_stateNext = ST_VALID;
          end
        end
      end
      ST_VALID: begin
        if (w_redirect) begin
          w_pcNext    = w_target;
          w_stateNext = ST_REQ;
        end else if (!stall) begin
          w_pcNext    = r_pc + PC_STEP;
          w_stateNext = ST_REQ;
        end
      end
      ST_ERR: begin
        w_stateNext = ST_ERR;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase

    // A misaligned target from any live state is fatal until the next reset
    if ((r_state != ST_ERR) && w_redirect && w_targetBad) begin
      w_stateNext = ST_ERR;
      w_pcNext    = r_pc;
      w_killNext  = 1'b0;
      w_latch     = 1'b0;
    end
  end

  // The issued address only moves once the outstanding request has been acknowledged
  always_comb begin
    w_addrNext = w_pcNext;
    if (((r_state == ST_REQ) && !imem_ack) || (w_stateNext == ST_ERR)) begin
      w_addrNext = r_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_VECTOR;
      r_addr     <= RESET_VECTOR;
      r_kill     <= 1'b0;
      r_instrOut <= 32'h0;
      r_instrPc  <= 32'h0;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      r_addr  <= w_addrNext;
      r_kill  <= w_killNext;
      if (w_latch) begin
        r_instrOut <= imem_rdata;
        r_instrPc  <= r_pc;
      end
    end
  end

  assign imem_req     = (r_state == ST_REQ);
  assign imem_addr    = r_addr;
  assign instr_valid  = (r_state == ST_VALID);
  assign instr_out    = r_instrOut;
  assign instr_pc     = r_instrPc;
  assign misalign_err = (r_state == ST_ERR);

endmodule
